led_pattern_engine: RTL and testbench
=====================================

# led_pattern_engine

Parametrised LED pattern generator, successor to the board-level ten-LED string-light shifter. Drives a WIDTH-bit LED bank from a programmable-rate step engine supporting four modes: serial shift-in right, serial shift-in left, rotate, and bounce. It adds parallel load and a step enable, and exposes a step strobe and direction flag for chaining and status. It sits between board switch/key synchronisers and the LEDR outputs.

## Interface
- WIDTH, 10, number of LEDs (≥ 2)
- DIV_W, 24, width of the rate prescaler counter and rate input
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- enable  input  1  1 = prescaler counts and steps occur; 0 = freeze counter and pattern
- mode  input  2  00 shift-in right, 01 shift-in left, 10 rotate right, 11 bounce
- in  input  1  serial bit for modes 00/01
- load  input  1  parallel-load strobe
- load_value  input  WIDTH  pattern captured on load
- rate  input  DIV_W  step every rate+1 enabled cycles
- leds  output  WIDTH  current pattern
- step  output  1  one-cycle pulse, high in the cycle after leds advanced
- dir  output  1  bounce direction: 0 = moving right (toward bit 0), 1 = moving left

## Operation
- Reset: leds = 0, cnt = 0, dir = 0, step = 0.
- Prescaler: cnt is DIV_W bits.
  - When enable=1 and cnt ≥ rate: a step event occurs and cnt ← 0.
  - Otherwise, when enable=1: cnt ← cnt+1.
  - When enable=0: cnt, leds and dir hold.
  - The ≥ compare makes lowering rate mid-count take effect on the next cycle with no wrap through 2^DIV_W.
- Priority per cycle: reset > load > step event > hold.
- Load: leds ← load_value, cnt ← 0, dir ← 0. Load occurs regardless of enable. There is no step event and step=0 in the following cycle.
- Step event by mode (mode sampled at the step edge; a mode change never resets cnt):
  - 00: leds ← {in, leds[WIDTH-1:1]}.
  - 01: leds ← {leds[WIDTH-2:0], in}.
  - 10: leds ← {leds[0], leds[WIDTH-1:1]}.
  - 11 bounce: logical shift, zero fill, direction from dir.
    - If leds[0]=1 and leds[WIDTH-1]=1: leds and dir hold.
    - Else if dir=0 and leds[0]=1: dir ← 1 and leds shift left this same step, so there is no dwell at the end.
    - Else if dir=1 and leds[WIDTH-1]=1: dir ← 0 and leds shift right this same step.
    - Else: shift right if dir=0, left if dir=1.
    - All-zero pattern stays zero; dir is unchanged.
- dir changes only in mode 11, or on load or reset. It holds through other modes.

## Timing
- All outputs are registered. leds changes on the clock edge where the step event is detected.
- step=1 for exactly the one cycle following each step event. step=0 after reset and after load.
- rate=R with enable held high: first step event R+1 cycles after reset or load deassertion, then every R+1 cycles.
- rate=0: a step event on every enabled cycle. step stays high continuously while enabled.
- in, mode and load_value are sampled only at the edge where they are used. No internal synchroniser is included; inputs must be pre-synchronised upstream.
- Reset asserted mid-count or mid-bounce clears state on that edge. The following cycle behaves as the first cycle after reset.

## Test plan
- Reset → leds=0, step=0, dir=0. Then mode=00, rate=0, enable=1, in=1 for 3 cycles then in=0 → leds 10'h200, 10'h300, 10'h380, then 10'h1C0.
- Rate spacing: rate=3, mode=10, load 10'h001 → step pulses exactly every 4 cycles; leds 10'h200, 10'h100, … wrapping back to 10'h001 after 10 steps.
- Bounce: WIDTH=10, mode=11, rate=0, load 10'h001 → first step 10'h002 with dir=1. Continues to 10'h200, next step 10'h100 with dir=0. Both ends set (load 10'h201) → pattern holds.
- Load priority: load=1 coincident with a step event → leds=load_value, cnt=0, step=0 next cycle. First step then occurs rate+1 cycles later.
- Enable freeze: deassert enable mid-count for 5 cycles → leds, cnt and dir unchanged, no step. Re-enable → counting resumes from the frozen cnt.
- Reset mid-operation: assert reset during bounce with dir=1 → next cycle leds=0, dir=0, step=0. Lowering rate from 100 to 2 while cnt=50 → step event on the next enabled cycle.

Source files
------------

// File: rtl/led_pattern_engine_if.sv
// Control and status bundle between the switch/key synchronisers and the LED pattern engine.
interface led_pattern_engine_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DIV_W = 24
);
  logic             enable;
  logic [1:0]       mode;
  logic             in;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [DIV_W-1:0] rate;
  logic [WIDTH-1:0] leds;
  logic             step;
  logic             dir;

  modport master (
    output enable, mode, in, load, load_value, rate,
    input  leds, step, dir
  );

  modport slave (
    input  enable, mode, in, load, load_value, rate,
    output leds, step, dir
  );
endinterface

// File: rtl/led_pattern_engine.sv
// Programmable-rate LED pattern engine: shift-in right/left, rotate and bounce modes,
// with parallel load, step enable, and registered step strobe / bounce direction outputs.
module led_pattern_engine #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DIV_W = 24
) (
  input logic                  clk,
  input logic                  reset,
  led_pattern_engine_if.slave  bus_io
);

  typedef enum logic [1:0] {
    ModeShiftR = 2'b00,
    ModeShiftL = 2'b01,
    ModeRotR   = 2'b10,
    ModeBounce = 2'b11
  } mode_e;

  logic [WIDTH-1:0] leds_q, leds_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             step_evt;
  mode_e            mode;

  assign mode = mode_e'(bus_io.mode);
  // >= rather than == so a lowered rate takes effect without wrapping the counter.
  assign step_evt = bus_io.enable && (cnt_q >= bus_io.rate);

  always_comb begin
    leds_d = leds_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    if (bus_io.load) begin
      leds_d = bus_io.load_value;
      cnt_d  = '0;
      dir_d  = 1'b0;
    end else if (step_evt) begin
      cnt_d  = '0;
      step_d = 1'b1;
      unique case (mode)
        ModeShiftR: leds_d = {bus_io.in, leds_q[WIDTH-1:1]};
        ModeShiftL: leds_d = {leds_q[WIDTH-2:0], bus_io.in};
        ModeRotR:   leds_d = {leds_q[0], leds_q[WIDTH-1:1]};
        ModeBounce: begin
          if (leds_q[0] && leds_q[WIDTH-1]) begin
            leds_d = leds_q;
          end else if (!dir_q && leds_q[0]) begin
            // Reverse and move on the same step so the end LED does not dwell.
            dir_d  = 1'b1;
            leds_d = {leds_q[WIDTH-2:0], 1'b0};
          end else if (dir_q && leds_q[WIDTH-1]) begin
            dir_d  = 1'b0;
            leds_d = {1'b0, leds_q[WIDTH-1:1]};
          end else if (dir_q) begin
            leds_d = {leds_q[WIDTH-2:0], 1'b0};
          end else begin
            leds_d = {1'b0, leds_q[WIDTH-1:1]};
          end
        end
        default: leds_d = leds_q;
      endcase
    end else if (bus_io.enable) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
    end else begin
      leds_q <= leds_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign bus_io.leds = leds_q;
  assign bus_io.step = step_q;
  assign bus_io.dir  = dir_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: vector table, directed multi-cycle sequences,
// and randomized traffic compared against an arithmetic reference model.
module tb_led_pattern_engine;
  localparam int unsigned W  = 10;
  localparam int unsigned DW = 24;
  localparam int unsigned FULL = 1 << W;
  localparam int unsigned HALF = 1 << (W - 1);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_pattern_engine_if #(.WIDTH(W), .DIV_W(DW)) bus ();

  led_pattern_engine #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state
  int unsigned m_leds, m_cnt;
  bit          m_dir, m_step;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_update();
    int unsigned v;
    bit lo, hi;
    v = m_leds;
    if (reset) begin
      m_leds = 0; m_cnt = 0; m_dir = 0; m_step = 0;
      return;
    end
    m_step = 0;
    if (bus.load) begin
      m_leds = int'(bus.load_value); m_cnt = 0; m_dir = 0;
    end else if (bus.enable) begin
      if (m_cnt >= int'(bus.rate)) begin
        m_cnt  = 0;
        m_step = 1;
        case (bus.mode)
          2'd0: v = v / 2 + (bus.in ? HALF : 0);
          2'd1: v = (v * 2) % FULL + (bus.in ? 1 : 0);
          2'd2: v = v / 2 + (v % 2) * HALF;
          default: begin
            lo = (v % 2) == 1;
            hi = (v / HALF) == 1;
            if (!(lo && hi)) begin
              if (!m_dir && lo) m_dir = 1;
              else if (m_dir && hi) m_dir = 0;
              v = m_dir ? (v * 2) % FULL : v / 2;
            end
          end
        endcase
        m_leds = v;
      end else begin
        m_cnt++;
      end
    end
  endfunction

  // One clock: advance the model, then sample DUT 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("model_leds", bus.leds, m_leds);
    chk("model_step", bus.step, m_step);
    chk("model_dir",  bus.dir,  m_dir);
  endtask

  task automatic drive(input bit rst, input bit en, input bit [1:0] md, input bit sin,
                       input bit ld, input int unsigned lv, input int unsigned rt);
    reset          = rst;
    bus.enable     = en;
    bus.mode       = md;
    bus.in         = sin;
    bus.load       = ld;
    bus.load_value = W'(lv);
    bus.rate       = DW'(rt);
  endtask

  typedef struct {
    bit          rst, en;
    bit [1:0]    md;
    bit          sin, ld;
    int unsigned lv, rt;
    int unsigned e_leds;
    bit          e_step, e_dir;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, bit en, bit [1:0] md, bit sin, bit ld, int unsigned lv,
                              int unsigned rt, int unsigned el, bit es, bit ed);
    vec_t v;
    v.rst = rst; v.en = en; v.md = md; v.sin = sin; v.ld = ld; v.lv = lv; v.rt = rt;
    v.e_leds = el; v.e_step = es; v.e_dir = ed;
    vecs.push_back(v);
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);

    //  rst en md in ld lv      rt  leds    step dir
    add(1, 0, 0, 0, 0, 0,      0, 'h000, 0, 0);
    add(0, 1, 0, 1, 0, 0,      0, 'h200, 1, 0);
    add(0, 1, 0, 1, 0, 0,      0, 'h300, 1, 0);
    add(0, 1, 0, 1, 0, 0,      0, 'h380, 1, 0);
    add(0, 1, 0, 0, 0, 0,      0, 'h1C0, 1, 0);
    add(0, 1, 1, 1, 0, 0,      0, 'h381, 1, 0);
    add(0, 1, 3, 0, 1, 'h001,  0, 'h001, 0, 0);
    add(0, 1, 3, 0, 0, 0,      0, 'h002, 1, 1);
    add(0, 1, 3, 0, 0, 0,      0, 'h004, 1, 1);
    add(0, 1, 3, 0, 1, 'h200,  0, 'h200, 0, 0);
    add(0, 1, 3, 0, 0, 0,      0, 'h100, 1, 0);
    add(0, 1, 3, 0, 1, 'h100,  0, 'h100, 0, 0);
    add(0, 1, 1, 0, 0, 0,      0, 'h200, 1, 0);
    add(0, 1, 3, 0, 0, 0,      0, 'h100, 1, 0);
    add(0, 1, 3, 0, 1, 'h201,  0, 'h201, 0, 0);
    add(0, 1, 3, 0, 0, 0,      0, 'h201, 1, 0);
    add(0, 1, 3, 0, 1, 'h000,  0, 'h000, 0, 0);
    add(0, 1, 3, 0, 0, 0,      0, 'h000, 1, 0);
    add(0, 1, 3, 0, 1, 'h040,  0, 'h040, 0, 0);
    add(0, 1, 3, 0, 1, 'h001,  0, 'h001, 0, 0);
    add(0, 1, 3, 0, 0, 0,      0, 'h002, 1, 1);
    add(0, 1, 2, 0, 0, 0,      0, 'h001, 1, 1);
    add(0, 1, 3, 0, 0, 0,      0, 'h002, 1, 1);
    add(1, 1, 3, 0, 0, 0,      0, 'h000, 0, 0);
    add(0, 1, 2, 0, 1, 'h003,  0, 'h003, 0, 0);
    add(0, 1, 2, 0, 0, 0,      0, 'h201, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].md, vecs[i].sin, vecs[i].ld, vecs[i].lv,
            vecs[i].rt);
      tick();
      chk($sformatf("vec%0d_leds", i), bus.leds, vecs[i].e_leds);
      chk($sformatf("vec%0d_step", i), bus.step, vecs[i].e_step);
      chk($sformatf("vec%0d_dir", i),  bus.dir,  vecs[i].e_dir);
    end

    // Rate spacing: rotate with rate=3, step every 4th cycle, back home after 10 steps.
    drive(0, 1, 2, 0, 1, 'h001, 3);
    tick();
    bus.load = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk($sformatf("spacing_step%0d", k), bus.step, (k % 4 == 0) ? 1 : 0);
      if (k == 4) chk("spacing_first", bus.leds, 'h200);
      if (k == 8) chk("spacing_second", bus.leds, 'h100);
    end
    chk("spacing_wrap", bus.leds, 'h001);

    // Load coincident with a step event wins; next step rate+1 cycles later.
    drive(0, 1, 2, 0, 1, 'h001, 3);
    tick();
    bus.load = 0;
    repeat (3) tick();
    bus.load = 1; bus.load_value = W'('h155);
    tick();
    chk("ldprio_leds", bus.leds, 'h155);
    chk("ldprio_step", bus.step, 0);
    bus.load = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("ldprio_after%0d", k), bus.step, (k == 4) ? 1 : 0);
    end

    // Enable freeze mid-count, then resume from the frozen count.
    drive(0, 1, 3, 0, 1, 'h001, 6);
    tick();
    bus.load = 0;
    repeat (3) tick();
    bus.enable = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("freeze_step", bus.step, 0);
      chk("freeze_leds", bus.leds, 'h001);
    end
    bus.enable = 1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("resume%0d", k), bus.step, (k == 4) ? 1 : 0);
    end
    chk("resume_leds", bus.leds, 'h002);
    chk("resume_dir", bus.dir, 1);

    // Reset during bounce with dir=1.
    reset = 1;
    tick();
    chk("rst_leds", bus.leds, 0);
    chk("rst_dir", bus.dir, 0);
    chk("rst_step", bus.step, 0);
    reset = 0;

    // Lowering rate below the current count fires on the next enabled cycle.
    drive(0, 1, 2, 0, 1, 'h010, 100);
    tick();
    bus.load = 0;
    repeat (50) tick();
    chk("lower_before", bus.step, 0);
    bus.rate = DW'(2);
    tick();
    chk("lower_step", bus.step, 1);
    chk("lower_leds", bus.leds, 'h008);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0), $urandom_range(0, FULL - 1),
            $urandom_range(0, 4));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
